// File: rtl/byte_packer_nx_if.sv
// Handshake bundle for byte_packer_nx: narrow lane input side and packed word output side.
// master = surrounding environment (lane source and word sink), slave = the packer.
interface byte_packer_nx_if #(
   parameter int IN_W  = 8,
   parameter int LANES = 4
);
   logic [IN_W-1:0]       data_in;
   logic                  valid_in;
   logic                  ready_in;
   logic                  flush;
   logic [LANES*IN_W-1:0] data_out;
   logic [LANES-1:0]      mask_out;
   logic                  valid_out;
   logic                  ready_out;

   modport master (
      output data_in, valid_in, flush, ready_out,
      input  ready_in, data_out, mask_out, valid_out
   );

   modport slave (
      input  data_in, valid_in, flush, ready_out,
      output ready_in, data_out, mask_out, valid_out
   );
endinterface

// File: rtl/byte_packer_nx.sv
// Packs LANES narrow lanes into one wide word with valid/ready on both sides, flush and lane mask.
// Optional BYTE_PACKER_STATS_EN adds words_cnt (output transfers) and stall_cnt (stalled valid cycles).
//
// state | meaning
// FILL  | accepting lanes into the accumulator
// HOLD  | accumulator closed, waiting for the output register to drain
module byte_packer_nx #(
   parameter int IN_W      = 8,
   parameter int LANES     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk_4f,
   input  logic             reset,
   byte_packer_nx_if.slave  bus
`ifdef BYTE_PACKER_STATS_EN
   ,
   output logic [15:0]      words_cnt,
   output logic [15:0]      stall_cnt
`endif
);
   localparam int W     = LANES * IN_W;
   localparam int CNT_W = $clog2(LANES + 1);

   typedef enum logic {FILL, HOLD} state_t;

   state_t           state, state_nxt;
   logic [W-1:0]     acc_data, acc_data_nxt;
   logic [LANES-1:0] acc_mask, acc_mask_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [W-1:0]     out_data, out_data_nxt;
   logic [LANES-1:0] out_mask, out_mask_nxt;
   logic             out_valid, out_valid_nxt;

   logic             accept, drain, close;
   logic [W-1:0]     fill_data;
   logic [LANES-1:0] fill_mask;
   logic [CNT_W-1:0] fill_cnt;
   int               lane_idx;

   assign bus.ready_in  = (state == FILL);
   assign bus.data_out  = out_data;
   assign bus.mask_out  = out_mask;
   assign bus.valid_out = out_valid;

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         state     <= FILL;
         acc_data  <= '0;
         acc_mask  <= '0;
         cnt       <= '0;
         out_data  <= '0;
         out_mask  <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         acc_data  <= acc_data_nxt;
         acc_mask  <= acc_mask_nxt;
         cnt       <= cnt_nxt;
         out_data  <= out_data_nxt;
         out_mask  <= out_mask_nxt;
         out_valid <= out_valid_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      acc_data_nxt  = acc_data;
      acc_mask_nxt  = acc_mask;
      cnt_nxt       = cnt;
      out_data_nxt  = out_data;
      out_mask_nxt  = out_mask;
      out_valid_nxt = out_valid;

      accept   = bus.valid_in && (state == FILL);
      drain    = out_valid && bus.ready_out;
      lane_idx = MSB_FIRST ? (LANES - 1 - int'(cnt)) : int'(cnt);

      // Accumulator contents as they would be after this cycle's lane.
      fill_data = acc_data;
      fill_mask = acc_mask;
      for (int k = 0; k < LANES; k++) begin
         if (accept && (k == lane_idx)) begin
            fill_data[k*IN_W +: IN_W] = bus.data_in;
            fill_mask[k]              = 1'b1;
         end
      end
      fill_cnt = cnt + {{(CNT_W-1){1'b0}}, accept};
      close    = (accept && (cnt == CNT_W'(LANES - 1))) ||
                 (bus.flush && (fill_cnt != '0));

      case (state)
         FILL: begin
            if (drain) out_valid_nxt = 1'b0;
            if (close && (!out_valid || drain)) begin
               out_data_nxt  = fill_data;
               out_mask_nxt  = fill_mask;
               out_valid_nxt = 1'b1;
               acc_data_nxt  = '0;
               acc_mask_nxt  = '0;
               cnt_nxt       = '0;
            end else begin
               acc_data_nxt = fill_data;
               acc_mask_nxt = fill_mask;
               cnt_nxt      = fill_cnt;
               if (close) state_nxt = HOLD;
            end
         end
         HOLD: begin
            // The held word replaces the departing one, so the output never bubbles.
            if (drain) begin
               out_data_nxt  = acc_data;
               out_mask_nxt  = acc_mask;
               out_valid_nxt = 1'b1;
               acc_data_nxt  = '0;
               acc_mask_nxt  = '0;
               cnt_nxt       = '0;
               state_nxt     = FILL;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

`ifdef BYTE_PACKER_STATS_EN
   always_ff @(posedge clk_4f) begin
      if (reset) begin
         words_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (out_valid && bus.ready_out) words_cnt <= words_cnt + 16'd1;
         if (bus.valid_in && (state != FILL) && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_byte_packer_nx.sv
// Scoreboard bench for byte_packer_nx: MSB-first instance (dut0) and LSB-first instance (dut1).
module tb_byte_packer_nx;
   logic clk_4f = 1'b0;
   logic reset;
   always #5 clk_4f = ~clk_4f;

   byte_packer_nx_if #(.IN_W(8), .LANES(4)) bus0 ();
   byte_packer_nx_if #(.IN_W(8), .LANES(4)) bus1 ();

`ifdef BYTE_PACKER_STATS_EN
   logic [15:0] words0, stall0, words1, stall1;
`endif

   byte_packer_nx #(.IN_W(8), .LANES(4), .MSB_FIRST(1'b1)) dut0 (
      .clk_4f(clk_4f), .reset(reset), .bus(bus0)
`ifdef BYTE_PACKER_STATS_EN
      , .words_cnt(words0), .stall_cnt(stall0)
`endif
   );

   byte_packer_nx #(.IN_W(8), .LANES(4), .MSB_FIRST(1'b0)) dut1 (
      .clk_4f(clk_4f), .reset(reset), .bus(bus1)
`ifdef BYTE_PACKER_STATS_EN
      , .words_cnt(words1), .stall_cnt(stall1)
`endif
   );

   int n_cmp  = 0;
   int n_fail = 0;
   logic [35:0] q0[$];
   logic [35:0] q1[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitors: pop one expected {mask,data} per output transfer.
   always @(negedge clk_4f) begin
      if (!reset && bus0.valid_out && bus0.ready_out) begin
         if (q0.size() == 0) check("dut0_unexpected_word", {28'd0, bus0.mask_out, bus0.data_out}, 64'hDEAD);
         else check("dut0_word", {28'd0, bus0.mask_out, bus0.data_out}, {28'd0, q0.pop_front()});
      end
      if (!reset && bus1.valid_out && bus1.ready_out) begin
         if (q1.size() == 0) check("dut1_unexpected_word", {28'd0, bus1.mask_out, bus1.data_out}, 64'hDEAD);
         else check("dut1_word", {28'd0, bus1.mask_out, bus1.data_out}, {28'd0, q1.pop_front()});
      end
   end

   task automatic send0(input logic [7:0] d, input logic v, input logic f);
      bus0.data_in = d; bus0.valid_in = v; bus0.flush = f;
      @(posedge clk_4f); #1;
      bus0.valid_in = 1'b0; bus0.flush = 1'b0;
   endtask

   task automatic send1(input logic [7:0] d, input logic v, input logic f);
      bus1.data_in = d; bus1.valid_in = v; bus1.flush = f;
      @(posedge clk_4f); #1;
      bus1.valid_in = 1'b0; bus1.flush = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int cyc = 0;
      while ((q0.size() != 0 || q1.size() != 0) && cyc < 40) begin
         @(posedge clk_4f); #1;
         cyc++;
      end
      if (q0.size() != 0 || q1.size() != 0) begin
         n_cmp++; n_fail++;
         $display("FAIL %s_timeout: pending %0d/%0d words expected 0", name, q0.size(), q1.size());
         q0.delete(); q1.delete();
      end
      @(posedge clk_4f); #1;
   endtask

   initial begin
      reset = 1'b1;
      bus0.data_in = '0; bus0.valid_in = 1'b0; bus0.flush = 1'b0; bus0.ready_out = 1'b1;
      bus1.data_in = '0; bus1.valid_in = 1'b0; bus1.flush = 1'b0; bus1.ready_out = 1'b1;
      repeat (2) @(posedge clk_4f);
      #1;
      check("rst_data_out",  {32'd0, bus0.data_out}, 64'h0);
      check("rst_mask_out",  {60'd0, bus0.mask_out}, 64'h0);
      check("rst_valid_out", {63'd0, bus0.valid_out}, 64'h0);
      check("rst_ready_in",  {63'd0, bus0.ready_in}, 64'h1);
      check("rst_valid_out1", {63'd0, bus1.valid_out}, 64'h0);
      reset = 1'b0;

      // Full word, latency 1, single-cycle valid pulse
      q0.push_back({4'hF, 32'hFFFFFFFF});
      repeat (4) send0(8'hFF, 1'b1, 1'b0);
      check("t1_latency", {63'd0, bus0.valid_out}, 64'h1);
      wait_drain("t1");
      check("t1_pulse", {63'd0, bus0.valid_out}, 64'h0);

      // Idle cycles with data present are ignored
      q0.push_back({4'hF, 32'hDDDDDDDD});
      send0(8'hDD, 1'b1, 1'b0); send0(8'hDD, 1'b1, 1'b0);
      repeat (4) send0(8'hAA, 1'b0, 1'b0);
      send0(8'hDD, 1'b1, 1'b0); send0(8'hDD, 1'b1, 1'b0);
      wait_drain("t2");

      // Flush with the final lane, next word restarts at the top lane
      q0.push_back({4'hE, 32'h01020300});
      send0(8'h01, 1'b1, 1'b0); send0(8'h02, 1'b1, 1'b0); send0(8'h03, 1'b1, 1'b1);
      q0.push_back({4'hF, 32'h11223344});
      send0(8'h11, 1'b1, 1'b0); send0(8'h22, 1'b1, 1'b0);
      send0(8'h33, 1'b1, 1'b0); send0(8'h44, 1'b1, 1'b0);
      wait_drain("t3");
      // Flush on an empty accumulator produces nothing
      send0(8'h00, 1'b0, 1'b1);
      repeat (3) send0(8'h00, 1'b0, 1'b0);
      check("t3_empty_flush", {63'd0, bus0.valid_out}, 64'h0);

      // LSB-first placement and flush
      q1.push_back({4'hF, 32'h04030201});
      send1(8'h01, 1'b1, 1'b0); send1(8'h02, 1'b1, 1'b0);
      send1(8'h03, 1'b1, 1'b0); send1(8'h04, 1'b1, 1'b0);
      q1.push_back({4'h3, 32'h00000B0A});
      send1(8'h0A, 1'b1, 1'b0); send1(8'h0B, 1'b1, 1'b1);
      wait_drain("t4");

      // Backpressure: one word held in output, second in accumulator (HOLD)
      bus0.ready_out = 1'b0;
      q0.push_back({4'hF, 32'hAABBCCDD});
      q0.push_back({4'hF, 32'h01020304});
      send0(8'hAA, 1'b1, 1'b0); send0(8'hBB, 1'b1, 1'b0);
      send0(8'hCC, 1'b1, 1'b0); send0(8'hDD, 1'b1, 1'b0);
      send0(8'h01, 1'b1, 1'b0); send0(8'h02, 1'b1, 1'b0);
      send0(8'h03, 1'b1, 1'b0); send0(8'h04, 1'b1, 1'b0);
      check("t5_hold_ready_in", {63'd0, bus0.ready_in}, 64'h0);
      check("t5_hold_data", {32'd0, bus0.data_out}, 64'hAABBCCDD);
      repeat (3) send0(8'h99, 1'b1, 1'b0);
      check("t5_still_hold", {63'd0, bus0.ready_in}, 64'h0);
      bus0.ready_out = 1'b1;
      @(posedge clk_4f); #1;
      check("t5_b2b_valid", {63'd0, bus0.valid_out}, 64'h1);
      check("t5_b2b_data", {32'd0, bus0.data_out}, 64'h01020304);
      wait_drain("t5");
`ifdef BYTE_PACKER_STATS_EN
      check("t5_stall_cnt", {48'd0, stall0}, 64'd3);
      check("t5_words_cnt", {48'd0, words0}, 64'd6);
`endif

      // Reset mid-word discards the partial accumulator
      send0(8'h00, 1'b1, 1'b0); send0(8'h00, 1'b1, 1'b0);
      reset = 1'b1;
      @(posedge clk_4f); #1;
      reset = 1'b0;
      q0.push_back({4'hF, 32'h05060708});
      send0(8'h05, 1'b1, 1'b0); send0(8'h06, 1'b1, 1'b0);
      send0(8'h07, 1'b1, 1'b0); send0(8'h08, 1'b1, 1'b0);
      wait_drain("t6");
`ifdef BYTE_PACKER_STATS_EN
      check("t6_words_cnt", {48'd0, words0}, 64'd1);
      check("t6_stall_cnt", {48'd0, stall0}, 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
